rect_bounce: RTL and testbench
==============================

# rect_bounce

Frame-synchronous animated-rectangle stage. It sits between the 480p display timing generator and the paint/colour stage. Once per frame, during vertical blanking, it moves a fixed-size rectangle by a fixed step, bouncing it off the screen edges. Every pixel cycle it also emits a registered, pipeline-aligned "inside rectangle" flag together with the delayed coordinates and data enable.

## Interface
Parameters
- CORDW, 10: coordinate width
- H_RES, 640: active width in pixels
- V_RES, 480: active height in lines
- RECT_W, 200: rectangle width; legal range 1..H_RES
- RECT_H, 160: rectangle height; legal range 1..V_RES
- SPEED, 2: pixels moved per frame on each axis; legal range 1..min(RECT_W, RECT_H)
- X0, 220: reset left edge; must be ≤ H_RES-RECT_W
- Y0, 160: reset top edge; must be ≤ V_RES-RECT_H

Ports
- clk_pix  in  1  pixel clock
- rst_pix_n  in  1  reset, synchronous, active-low
- sx  in  CORDW  horizontal position from the timing generator
- sy  in  CORDW  vertical position from the timing generator
- de  in  1  data enable from the timing generator
- run  in  1  motion enable; sampled only on the update strobe
- sx_out  out  CORDW  sx delayed 1 cycle
- sy_out  out  CORDW  sy delayed 1 cycle
- de_out  out  1  de delayed 1 cycle
- rect_out  out  1  registered inside-rectangle flag, aligned with sx_out/sy_out
- rect_x  out  CORDW  current left edge
- rect_y  out  CORDW  current top edge
- bounce  out  1  one-cycle pulse on any edge reflection

## Operation
- Update strobe: `upd = (sx == 0) && (sy == V_RES)`. This is the first cycle of the first blanking line. There is exactly one strobe per frame, so position is stable through the whole active area.
- Direction is held in two 2-state FSMs:
  - horizontal: RIGHT ↔ LEFT
  - vertical: DOWN ↔ UP
- On `upd && run`, the horizontal axis updates as follows (vertical is identical with y, RECT_H, V_RES, DOWN/UP):
  - RIGHT and `x+RECT_W+SPEED > H_RES`: x ← H_RES-RECT_W, state → LEFT, reflect.
  - RIGHT otherwise: x ← x+SPEED.
  - LEFT and `x < SPEED`: x ← 0, state → RIGHT, reflect.
  - LEFT otherwise: x ← x-SPEED.
- Both axes may reflect on the same strobe (corner hit). In that case both FSMs flip and bounce is asserted for a single cycle.
- On `upd && !run`: position, direction and bounce are unchanged or 0, respectively.
- Hit test: `rect_out ← (sx ≥ x) && (sx < x+RECT_W) && (sy ≥ y) && (sy < y+RECT_H)`.
  - Left and top edges are inclusive; right and bottom edges are exclusive.
  - Sums are evaluated at CORDW+1 bits, so no wrap-around occurs.
  - rect_out is not gated by de; the paint stage gates it using de_out.
- The hit test uses the pre-update x/y in the strobe cycle. This is harmless because the strobe falls in blanking.

## Timing
- Reset (rst_pix_n low at a clk_pix edge) takes effect at that edge:
  - x=X0, y=Y0, state RIGHT/DOWN
  - rect_out=0, de_out=0, sx_out=0, sy_out=0, bounce=0
- Reset asserted mid-frame or mid-motion discards the current position and direction. There is no partial update.
- Pipeline latency is 1 cycle for sx_out, sy_out, de_out and rect_out. All four are mutually aligned.
- rect_x, rect_y and the direction FSMs update on the clock edge that samples upd. The new values are visible the cycle after the strobe.
- bounce is high only in the cycle after the strobe, and only if a reflection occurred.
- run is level-sensitive and sampled only at upd. A glitch on run outside the strobe cycle has no effect.

## Test plan
- **Reset:** hold rst_pix_n=0 for 3 cycles with random sx/sy/de → rect_x=220, rect_y=160, rect_out=0, de_out=0, bounce=0. Repeat with reset asserted mid-frame after several moves → same values.
- **Hit edges:** run=0, sy=160, sweep sx 218..421, with each (sx, sy) pair held one cycle → rect_out=1 exactly for sx=220..419, one cycle late. Then sx=300 with sy=159/160/319/320 → rect_out 0/1/1/0.
- **Motion:** run=1, drive (sx=0, sy=480) once → next cycle rect_x=222, rect_y=162. (sx=1, sy=480) and (sx=0, sy=479) → no change. run=0 at strobe → no change.
- **Right bounce** (X0=438, Y0=100): strobe 1 → x=440, bounce=0. Strobe 2 → x=440, state LEFT, bounce=1 for one cycle. Strobe 3 → x=438.
- **Corner** (X0=440, Y0=320, RECT_H=160): strobe → x=440, y=320, both directions flip, one bounce pulse. Next strobe → x=438, y=318.
- **Left/top clamp** (SPEED=3, state LEFT/UP via prior bounce, x=2, y=1): strobe → x=0, y=0, state RIGHT/DOWN, bounce=1.

Source files
------------

// File: rtl/rect_bounce.sv
// ---------------------------------------------------------------------------
// rect_bounce
//
// Animated-rectangle stage between the 480p timing generator and the paint
// stage. Once per frame, on the first cycle of the first blanking line, the
// rectangle is stepped by SPEED pixels on each axis and reflected off the
// screen edges. Every pixel cycle a registered inside-rectangle flag is
// produced, aligned with the one-cycle-delayed coordinates and data enable.
//
// Ports
//   clk_pix    in   pixel clock
//   rst_pix_n  in   synchronous active-low reset
//   sx, sy     in   current pixel coordinates from the timing generator
//   de         in   data enable from the timing generator
//   run        in   motion enable, only looked at on the update strobe
//   sx_out     out  sx delayed one cycle
//   sy_out     out  sy delayed one cycle
//   de_out     out  de delayed one cycle
//   rect_out   out  inside-rectangle flag, aligned with sx_out/sy_out
//   rect_x     out  current left edge of the rectangle
//   rect_y     out  current top edge of the rectangle
//   bounce     out  one-cycle pulse after a strobe that reflected an axis
// ---------------------------------------------------------------------------
module rect_bounce #(
   parameter int CORDW  = 10,
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int RECT_W = 200,
   parameter int RECT_H = 160,
   parameter int SPEED  = 2,
   parameter int X0     = 220,
   parameter int Y0     = 160
) (
   input  logic             clk_pix,
   input  logic             rst_pix_n,
   input  logic [CORDW-1:0] sx,
   input  logic [CORDW-1:0] sy,
   input  logic             de,
   input  logic             run,
   output logic [CORDW-1:0] sx_out,
   output logic [CORDW-1:0] sy_out,
   output logic             de_out,
   output logic             rect_out,
   output logic [CORDW-1:0] rect_x,
   output logic [CORDW-1:0] rect_y,
   output logic             bounce
);

   // Edge tests need two guard bits: pos + size + step can exceed 2**CORDW.
   localparam int EW = CORDW + 2;

   localparam logic [CORDW-1:0] V_RES_C = CORDW'(V_RES);
   localparam logic [CORDW-1:0] SPD_C   = CORDW'(SPEED);
   localparam logic [CORDW-1:0] X_MAX   = CORDW'(H_RES - RECT_W);
   localparam logic [CORDW-1:0] Y_MAX   = CORDW'(V_RES - RECT_H);
   localparam logic [CORDW-1:0] X0_C    = CORDW'(X0);
   localparam logic [CORDW-1:0] Y0_C    = CORDW'(Y0);

   localparam logic [EW-1:0] SPD_E  = EW'(SPEED);
   localparam logic [EW-1:0] RW_E   = EW'(RECT_W);
   localparam logic [EW-1:0] RH_E   = EW'(RECT_H);
   localparam logic [EW-1:0] HRES_E = EW'(H_RES);
   localparam logic [EW-1:0] VRES_E = EW'(V_RES);

   // Hit-test extents, one guard bit so x + RECT_W never wraps.
   localparam logic [CORDW:0] RW_H = (CORDW+1)'(RECT_W);
   localparam logic [CORDW:0] RH_H = (CORDW+1)'(RECT_H);

   typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} hdir_t;
   typedef enum logic {DIR_DOWN  = 1'b0, DIR_UP   = 1'b1} vdir_t;

   // True when the next step along one axis would leave the screen.
   // Moving toward zero: the step would go negative.
   // Moving away from zero: the far edge would pass the resolution.
   function automatic logic edge_reached(
      input logic [CORDW-1:0] pos,
      input logic             toward_zero,
      input logic [EW-1:0]    size,
      input logic [EW-1:0]    res
   );
      if (toward_zero)
         edge_reached = (pos < SPD_C);
      else
         edge_reached = (({2'b00, pos} + size + SPD_E) > res);
   endfunction

   // Next position along one axis; a reflecting step clamps to the edge.
   function automatic logic [CORDW-1:0] step_pos(
      input logic [CORDW-1:0] pos,
      input logic             toward_zero,
      input logic             hit,
      input logic [CORDW-1:0] far_pos
   );
      if (hit)
         step_pos = toward_zero ? '0 : far_pos;
      else if (toward_zero)
         step_pos = pos - SPD_C;
      else
         step_pos = pos + SPD_C;
   endfunction

   hdir_t            hdir, hdir_nx;
   vdir_t            vdir, vdir_nx;
   logic [CORDW-1:0] x, x_nx;
   logic [CORDW-1:0] y, y_nx;
   logic             upd, move;
   logic             h_hit, v_hit;
   logic             bounce_nx;

   logic [CORDW:0]   x_end, y_end;
   logic             in_rect_p0;

   logic [CORDW-1:0] sx_p1, sy_p1;
   logic             vld_p1;
   logic             rect_p1;
   logic             bounce_p1;

   // Exactly one strobe per frame, in blanking, so the rectangle is
   // stationary across the whole active area.
   assign upd  = (sx == '0) && (sy == V_RES_C);
   assign move = upd && run;

   assign h_hit = edge_reached(x, hdir == DIR_LEFT, RW_E, HRES_E);
   assign v_hit = edge_reached(y, vdir == DIR_UP,   RH_E, VRES_E);

   // ---- direction FSMs: state register -----------------------------------
   always_ff @(posedge clk_pix) begin
      if (!rst_pix_n) begin
         hdir <= DIR_RIGHT;
         vdir <= DIR_DOWN;
         x    <= X0_C;
         y    <= Y0_C;
      end else begin
         hdir <= hdir_nx;
         vdir <= vdir_nx;
         x    <= x_nx;
         y    <= y_nx;
      end
   end

   // ---- direction FSMs: next state ---------------------------------------
   always_comb begin
      hdir_nx = hdir;
      vdir_nx = vdir;
      x_nx    = x;
      y_nx    = y;
      if (move) begin
         x_nx = step_pos(x, hdir == DIR_LEFT, h_hit, X_MAX);
         y_nx = step_pos(y, vdir == DIR_UP,   v_hit, Y_MAX);
         if (h_hit)
            hdir_nx = (hdir == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
         if (v_hit)
            vdir_nx = (vdir == DIR_DOWN) ? DIR_UP : DIR_DOWN;
      end
   end

   // ---- direction FSMs: outputs ------------------------------------------
   // A corner hit flips both axes but still produces a single pulse.
   always_comb begin
      bounce_nx = move && (h_hit || v_hit);
   end

   // ---- stage p0: hit test on the incoming coordinates -------------------
   // Uses the pre-update position during the strobe cycle; that cycle is in
   // blanking, so nothing visible is affected.
   always_comb begin
      x_end      = {1'b0, x} + RW_H;
      y_end      = {1'b0, y} + RH_H;
      in_rect_p0 = ({1'b0, sx} >= {1'b0, x}) && ({1'b0, sx} < x_end) &&
                   ({1'b0, sy} >= {1'b0, y}) && ({1'b0, sy} < y_end);
   end

   // ---- stage p1: registered, mutually aligned outputs -------------------
   always_ff @(posedge clk_pix) begin
      if (!rst_pix_n) begin
         sx_p1     <= '0;
         sy_p1     <= '0;
         vld_p1    <= 1'b0;
         rect_p1   <= 1'b0;
         bounce_p1 <= 1'b0;
      end else begin
         sx_p1     <= sx;
         sy_p1     <= sy;
         vld_p1    <= de;
         rect_p1   <= in_rect_p0;
         bounce_p1 <= bounce_nx;
      end
   end

   assign sx_out   = sx_p1;
   assign sy_out   = sy_p1;
   assign de_out   = vld_p1;
   assign rect_out = rect_p1;
   assign rect_x   = x;
   assign rect_y   = y;
   assign bounce   = bounce_p1;

endmodule

// File: tb/tb_rect_bounce.sv
// ---------------------------------------------------------------------------
// tb_rect_bounce
//
// Two rect_bounce instances share one random stimulus stream:
//   u_a : default parameters (start 220,160, step 2)
//   u_b : starts in the bottom-right corner (440,320), step 3, so it
//         exercises a corner reflection first and later the left/top clamp.
// A position/velocity reference model predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_rect_bounce;
   localparam int CORDW  = 10;
   localparam int H_RES  = 640;
   localparam int V_RES  = 480;
   localparam int RECT_W = 200;
   localparam int RECT_H = 160;

   logic             clk_pix = 1'b0;
   logic             rst_pix_n;
   logic [CORDW-1:0] sx, sy;
   logic             de, run;

   logic [CORDW-1:0] a_sx_out, a_sy_out, a_rect_x, a_rect_y;
   logic             a_de_out, a_rect_out, a_bounce;
   logic [CORDW-1:0] b_sx_out, b_sy_out, b_rect_x, b_rect_y;
   logic             b_de_out, b_rect_out, b_bounce;

   always #5 clk_pix = ~clk_pix;

   rect_bounce u_a (
      .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
      .sx(sx), .sy(sy), .de(de), .run(run),
      .sx_out(a_sx_out), .sy_out(a_sy_out), .de_out(a_de_out),
      .rect_out(a_rect_out), .rect_x(a_rect_x), .rect_y(a_rect_y),
      .bounce(a_bounce)
   );

   rect_bounce #(
      .CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES),
      .RECT_W(RECT_W), .RECT_H(RECT_H), .SPEED(3), .X0(440), .Y0(320)
   ) u_b (
      .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
      .sx(sx), .sy(sy), .de(de), .run(run),
      .sx_out(b_sx_out), .sy_out(b_sy_out), .de_out(b_de_out),
      .rect_out(b_rect_out), .rect_x(b_rect_x), .rect_y(b_rect_y),
      .bounce(b_bounce)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: position and signed velocity per instance.
   int px0[2] = '{220, 440};
   int py0[2] = '{160, 320};
   int psp[2] = '{2, 3};
   int mx[2], my[2], mdx[2], mdy[2];
   int n_bounce[2] = '{0, 0};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_hit(input int k, input int x, input int y);
      return (x >= mx[k]) && (x < mx[k] + RECT_W) && (y >= my[k]) && (y < my[k] + RECT_H);
   endfunction

   task automatic model_reset(input int k);
      mx[k] = px0[k]; my[k] = py0[k]; mdx[k] = 1; mdy[k] = 1;
   endtask

   // Move one frame; a step that would leave the screen reverses the
   // velocity and parks the rectangle against that edge.
   task automatic model_move(input int k, output logic bnc);
      int nx, ny;
      bnc = 1'b0;
      nx = mx[k] + mdx[k] * psp[k];
      ny = my[k] + mdy[k] * psp[k];
      if (nx + RECT_W > H_RES) begin nx = H_RES - RECT_W; mdx[k] = -mdx[k]; bnc = 1'b1; end
      else if (nx < 0)         begin nx = 0;              mdx[k] = -mdx[k]; bnc = 1'b1; end
      if (ny + RECT_H > V_RES) begin ny = V_RES - RECT_H; mdy[k] = -mdy[k]; bnc = 1'b1; end
      else if (ny < 0)         begin ny = 0;              mdy[k] = -mdy[k]; bnc = 1'b1; end
      mx[k] = nx; my[k] = ny;
   endtask

   // Apply one cycle of inputs, then check both instances just after the edge.
   task automatic cycle(input logic r_n, input int isx, input int isy,
                        input logic ide, input logic irun);
      logic [CORDW-1:0] o_sx, o_sy, o_rx, o_ry;
      logic             o_de, o_rt, o_bn;
      logic             e_rt, e_bn, e_de;
      int               e_sx, e_sy;
      rst_pix_n = r_n;
      sx  = CORDW'(isx);
      sy  = CORDW'(isy);
      de  = ide;
      run = irun;
      @(posedge clk_pix);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            o_sx = a_sx_out; o_sy = a_sy_out; o_de = a_de_out; o_rt = a_rect_out;
            o_rx = a_rect_x; o_ry = a_rect_y; o_bn = a_bounce;
         end else begin
            o_sx = b_sx_out; o_sy = b_sy_out; o_de = b_de_out; o_rt = b_rect_out;
            o_rx = b_rect_x; o_ry = b_rect_y; o_bn = b_bounce;
         end
         if (!r_n) begin
            model_reset(k);
            e_sx = 0; e_sy = 0; e_de = 1'b0; e_rt = 1'b0; e_bn = 1'b0;
         end else begin
            e_sx = isx; e_sy = isy; e_de = ide;
            e_rt = model_hit(k, isx, isy);
            e_bn = 1'b0;
            if (isx == 0 && isy == V_RES && irun) model_move(k, e_bn);
            if (e_bn) n_bounce[k]++;
         end
         chk($sformatf("u%0d.sx_out", k),   32'(o_sx), 32'(e_sx));
         chk($sformatf("u%0d.sy_out", k),   32'(o_sy), 32'(e_sy));
         chk($sformatf("u%0d.de_out", k),   32'(o_de), 32'(e_de));
         chk($sformatf("u%0d.rect_out", k), 32'(o_rt), 32'(e_rt));
         chk($sformatf("u%0d.rect_x", k),   32'(o_rx), 32'(mx[k]));
         chk($sformatf("u%0d.rect_y", k),   32'(o_ry), 32'(my[k]));
         chk($sformatf("u%0d.bounce", k),   32'(o_bn), 32'(e_bn));
      end
   endtask

   function automatic int clip(input int v);
      if (v < 0) return 0;
      if (v > 1023) return 1023;
      return v;
   endfunction

   // Coordinate near one of the rectangle's edges (or anywhere inside it).
   function automatic int near_edge(input int lo, input int size);
      int off[6];
      off = '{-1, 0, 1, size - 1, size, size + 1};
      if ($urandom_range(0, 3) == 0) return clip(lo + int'($urandom_range(0, size - 1)));
      return clip(lo + off[$urandom_range(0, 5)]);
   endfunction

   initial begin
      int sel, k, isx, isy;
      model_reset(0);
      model_reset(1);

      // Reset held for three cycles with random coordinates.
      for (int i = 0; i < 3; i++)
         cycle(1'b0, int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
               1'($urandom), 1'($urandom));

      // Directed sweep across the top row of the default rectangle.
      for (int x = 218; x <= 421; x++) cycle(1'b1, x, 160, 1'b1, 1'b0);
      cycle(1'b1, 300, 159, 1'b1, 1'b0);
      cycle(1'b1, 300, 160, 1'b1, 1'b0);
      cycle(1'b1, 300, 319, 1'b1, 1'b0);
      cycle(1'b1, 300, 320, 1'b1, 1'b0);
      // Strobe with run low, near-miss strobes, then a real strobe.
      cycle(1'b1, 0, 480, 1'b0, 1'b0);
      cycle(1'b1, 1, 480, 1'b0, 1'b1);
      cycle(1'b1, 0, 479, 1'b0, 1'b1);
      cycle(1'b1, 0, 480, 1'b0, 1'b1);

      // Random traffic with frequent strobes; a reset lands mid-motion.
      for (int i = 0; i < 3000; i++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0, 1: begin isx = 0; isy = V_RES; end
            2:    begin isx = 0; isy = V_RES - 1; end
            3:    begin isx = 1; isy = V_RES; end
            4, 5: begin isx = int'($urandom_range(0, 799)); isy = int'($urandom_range(0, 524)); end
            default: begin
               k   = (sel < 8) ? 0 : 1;
               isx = near_edge(mx[k], RECT_W);
               isy = near_edge(my[k], RECT_H);
            end
         endcase
         cycle(!(i >= 2400 && i < 2403), isx, isy, 1'($urandom),
               ($urandom_range(0, 7) != 0));
      end

      // Both instances must have reflected at least once by now.
      chk("u0.bounced", 32'(n_bounce[0] > 0), 32'd1);
      chk("u1.bounced", 32'(n_bounce[1] > 0), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
